// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared single-port memory bus.
// slave = arbiter side, master = requesters/memory side (testbench or SoC glue).
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_stall;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_stall, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_stall, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline MEM stage (port 0) vs loader/debug (port 1).
// Define DMEM_ARB_STARVE_EN to build the port-1 starvation counter; otherwise port 0 has strict priority.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be within 1..15");
  end

  logic          gnt0;
  logic          gnt1;
  logic          stall;
  logic          force1;
  logic          en_next;
  logic          we_next;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] wdata_next;
  logic          rd_pend_reg;
  logic          rd_own_reg;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata_resp [2];

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  logic [3:0] wait_cnt_reg;

  assign force1 = bus.p1_req & (wait_cnt_reg == WAIT_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else if (!bus.p1_req || gnt1) begin
      wait_cnt_reg <= '0;
    end else if (wait_cnt_reg != WAIT_LIMIT) begin
      wait_cnt_reg <= wait_cnt_reg + 4'd1;
    end
  end
`else
  assign force1 = 1'b0;
`endif

  // Grants are gated by rst so every output sits at its reset value while reset is held.
  always_comb begin
    gnt0       = rst & bus.p0_req & ~force1;
    gnt1       = rst & bus.p1_req & ~gnt0;
    stall      = rst & bus.p0_req & ~gnt0;
    en_next    = gnt0 | gnt1;
    we_next    = 1'b0;
    addr_next  = '0;
    wdata_next = '0;
    if (gnt0) begin
      we_next    = bus.p0_we;
      addr_next  = bus.p0_addr;
      wdata_next = bus.p0_wdata;
    end else if (gnt1) begin
      we_next    = bus.p1_we;
      addr_next  = bus.p1_addr;
      wdata_next = bus.p1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_reg <= 1'b0;
      rd_own_reg  <= 1'b0;
    end else begin
      rd_pend_reg <= (gnt0 & ~bus.p0_we) | (gnt1 & ~bus.p1_we);
      rd_own_reg  <= gnt1;
    end
  end

  // Read data is steered only to the port that owns the outstanding read.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_resp
    assign rvalid[gi]     = rd_pend_reg & (rd_own_reg == 1'(gi));
    assign rdata_resp[gi] = rvalid[gi] ? bus.mem_rdata : '0;
  end

  assign bus.p0_stall  = stall;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = rvalid[0];
  assign bus.p1_rvalid = rvalid[1];
  assign bus.p0_rdata  = rdata_resp[0];
  assign bus.p1_rdata  = rdata_resp[1];
  assign bus.mem_en    = en_next;
  assign bus.mem_we    = we_next;
  assign bus.mem_addr  = addr_next;
  assign bus.mem_wdata = wdata_next;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter; expectations follow DMEM_ARB_STARVE_EN when defined.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port memory with one-cycle read latency.
  logic [31:0] mem_q [0:63];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_q[bus.mem_addr[7:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_q[bus.mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".p0_stall"},  32'(bus.p0_stall),  32'd0);
    chk({tag, ".p1_gnt"},    32'(bus.p1_gnt),    32'd0);
    chk({tag, ".p0_rvalid"}, 32'(bus.p0_rvalid), 32'd0);
    chk({tag, ".p1_rvalid"}, 32'(bus.p1_rvalid), 32'd0);
    chk({tag, ".p0_rdata"},  bus.p0_rdata,       32'd0);
    chk({tag, ".p1_rdata"},  bus.p1_rdata,       32'd0);
    chk({tag, ".mem_en"},    32'(bus.mem_en),    32'd0);
    chk({tag, ".mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, ".mem_addr"},  bus.mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,      32'd0);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    $display("t=%0t rst=%0b p0 req=%0b we=%0b addr=%h wdata=%h | p1 req=%0b we=%0b addr=%h wdata=%h",
             $time, rst, r0, w0, a0, d0, r1, w1, a1, d1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with random inputs, then released with idle inputs.
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1'($urandom), 1'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom), $urandom, $urandom);
      sample();
      chk_idle("reset");
    end
    cyc(); rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample(); chk_idle("post_reset");

    // Port 0 only: write then read back.
    cyc(); drive(1, 1, 32'h0, 32'hABCDEF12, 0, 0, 0, 0);
    sample();
    chk("p0wr.mem_en",    32'(bus.mem_en),   32'd1);
    chk("p0wr.mem_we",    32'(bus.mem_we),   32'd1);
    chk("p0wr.mem_addr",  bus.mem_addr,      32'h0);
    chk("p0wr.mem_wdata", bus.mem_wdata,     32'hABCDEF12);
    chk("p0wr.p0_stall",  32'(bus.p0_stall), 32'd0);
    cyc(); drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    sample();
    chk("p0rd.mem_en",    32'(bus.mem_en),    32'd1);
    chk("p0rd.mem_we",    32'(bus.mem_we),    32'd0);
    chk("p0rd.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    chk("p0rd.p0_stall",  32'(bus.p0_stall),  32'd0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("p0resp.p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("p0resp.p0_rdata",  bus.p0_rdata,       32'hABCDEF12);
    chk("p0resp.p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("p0resp.p1_rdata",  bus.p1_rdata,       32'd0);
    chk("p0resp.mem_en",    32'(bus.mem_en),    32'd0);

    // Preload 0x11 @0x8 and 0x22 @0xC, then alternate reads p0 -> p1.
    cyc(); drive(1, 1, 32'h8, 32'h11, 0, 0, 0, 0);
    cyc(); drive(1, 1, 32'hC, 32'h22, 0, 0, 0, 0);
    cyc(); drive(1, 0, 32'h8, 32'h0, 0, 0, 0, 0);
    sample();
    chk("alt0.mem_addr", bus.mem_addr,     32'h8);
    chk("alt0.p1_gnt",   32'(bus.p1_gnt),  32'd0);
    cyc(); drive(0, 0, 0, 0, 1, 0, 32'hC, 32'h0);
    sample();
    chk("alt1.p1_gnt",    32'(bus.p1_gnt),    32'd1);
    chk("alt1.mem_addr",  bus.mem_addr,       32'hC);
    chk("alt1.p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("alt1.p0_rdata",  bus.p0_rdata,       32'h11);
    chk("alt1.p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("alt1.p1_rdata",  bus.p1_rdata,       32'd0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("alt2.p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
    chk("alt2.p1_rdata",  bus.p1_rdata,       32'h22);
    chk("alt2.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    chk("alt2.p0_rdata",  bus.p0_rdata,       32'd0);

    // Conflict: port 0 reads 0x0 every cycle, port 1 writes 0x12345678 to 0x40.
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 1; i <= 4; i++) begin
      cyc(); drive(1, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h12345678);
      sample();
      chk($sformatf("starve%0d.p1_gnt", i),   32'(bus.p1_gnt),   32'd0);
      chk($sformatf("starve%0d.p0_stall", i), 32'(bus.p0_stall), 32'd0);
      chk($sformatf("starve%0d.mem_addr", i), bus.mem_addr,      32'h0);
    end
    cyc(); drive(1, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h12345678);
    sample();
    chk("starve5.p1_gnt",    32'(bus.p1_gnt),    32'd1);
    chk("starve5.p0_stall",  32'(bus.p0_stall),  32'd1);
    chk("starve5.mem_addr",  bus.mem_addr,       32'h40);
    chk("starve5.mem_we",    32'(bus.mem_we),    32'd1);
    chk("starve5.mem_wdata", bus.mem_wdata,      32'h12345678);
    chk("starve5.p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("starve5.p0_rdata",  bus.p0_rdata,       32'hABCDEF12);
`else
    for (int i = 1; i <= 20; i++) begin
      cyc(); drive(1, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h12345678);
      sample();
      chk($sformatf("strict%0d.p1_gnt", i),   32'(bus.p1_gnt),   32'd0);
      chk($sformatf("strict%0d.p0_stall", i), 32'(bus.p0_stall), 32'd0);
    end
    cyc(); drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h12345678);
    sample();
    chk("strict21.p1_gnt",   32'(bus.p1_gnt),   32'd1);
    chk("strict21.p0_stall", 32'(bus.p0_stall), 32'd0);
    chk("strict21.mem_addr", bus.mem_addr,      32'h40);
    chk("strict21.mem_we",   32'(bus.mem_we),   32'd1);
`endif

    // Fresh port-1 read right after its grant: waiting starts from zero again.
    cyc(); drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    sample();
    chk("post.p1_gnt",    32'(bus.p1_gnt),    32'd0);
    chk("post.p0_stall",  32'(bus.p0_stall),  32'd0);
    chk("post.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    chk("post.p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    cyc(); drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    sample();
    chk("p1rd.p1_gnt",    32'(bus.p1_gnt),    32'd1);
    chk("p1rd.mem_addr",  bus.mem_addr,       32'h40);
    chk("p1rd.mem_we",    32'(bus.mem_we),    32'd0);
    chk("p1rd.p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("p1rd.p0_rdata",  bus.p0_rdata,       32'hABCDEF12);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("p1resp.p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
    chk("p1resp.p1_rdata",  bus.p1_rdata,       32'h12345678);
    chk("p1resp.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);

    // Reset in the cycle after a granted read drops the response.
    cyc(); drive(1, 0, 32'h8, 32'h0, 0, 0, 0, 0);
    sample();
    chk("rstrd.mem_en", 32'(bus.mem_en), 32'd1);
    cyc(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk_idle("rstrd.inrst");
    cyc(); rst = 1'b1;
    sample();
    chk("rstrd.rel.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    cyc();
    sample();
    chk("rstrd.after.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    chk("rstrd.after.p1_rvalid", 32'(bus.p1_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage (port 0) and a secondary loader/debug master (port 1). Each cycle it grants the one memory access slot to one requester, drives the shared memory port, and stalls the pipeline when port 0 loses arbitration. It routes one-cycle-latency read data back to the requester that issued the read. An optional starvation counter bounds how long port 1 can wait.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, consecutive denied cycles before port 1 is forced a grant (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- p0_req  in  1  MEM-stage access request (memRead | memWrite)
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  AW  byte address
- p0_wdata  in  DW  write data
- p0_stall  out  1  port 0 denied this cycle; pipeline must hold EX/MEM
- p0_rvalid  out  1  p0_rdata valid
- p0_rdata  out  DW  read data
- p1_req, p1_we, p1_addr, p1_wdata  in  1/1/AW/DW  port 1 request (same meaning)
- p1_gnt  out  1  port 1 access accepted this cycle
- p1_rvalid  out  1  p1_rdata valid
- p1_rdata  out  DW  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read strobe

## Operation
- Grant is combinational from current requests and the registered wait counter. Each cycle at most one of gnt0 (internal) and p1_gnt is high.
- Priority: port 0 wins, except when `wait_cnt == MAX_WAIT` and p1_req=1. In that case port 1 wins and p0_stall=1.
- p0_stall = p0_req & ~gnt0. p1_gnt = p1_req & grant1.
- Memory port: mem_en = gnt0 | p1_gnt. mem_we, mem_addr, and mem_wdata come from the granted port. With no grant, mem_en=0, mem_we=0, and addr/wdata=0.
- Writes complete in the grant cycle. No response is returned for a write.
- Read tracking: on a granted read, the block registers `rd_pend=1` and `rd_own` (0 or 1). In the next cycle, the owner's rvalid=1 and rdata=mem_rdata. The non-owner's rdata=0.
- wait_cnt (4 bits):
  - Increments when p1_req & ~p1_gnt.
  - Clears when p1_gnt=1 or p1_req=0.
  - Saturates at MAX_WAIT.
- Requesters hold req/we/addr/wdata stable until granted. Port 1 may drop p1_req before a grant; that clears wait_cnt.

## Timing
- Reset values: p0_stall=0, p1_gnt=0, p0_rvalid=0, p1_rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wait_cnt=0, rd_pend=0.
- Read latency: rvalid asserts exactly 1 cycle after the grant cycle.
- Back-to-back reads by alternating owners are legal. The response to cycle N's read and the grant for cycle N+1 coexist.
- Writes have 0 additional latency.
- Simultaneous requests: port 1 can wait at most MAX_WAIT cycles. Its grant comes on cycle MAX_WAIT+1 after the request is asserted.
- Reset asserted mid-operation:
  - Outstanding read response is dropped and rvalid stays 0.
  - wait_cnt clears.
  - Outputs take reset values asynchronously.

## Configuration
- DMEM_ARB_STARVE_EN defined: wait_cnt and the forced port-1 grant are implemented as above.
- DMEM_ARB_STARVE_EN undefined: strict port-0 priority. wait_cnt is not built. p0_stall is never asserted. Port 1 is granted only in cycles where p0_req=0.

## Test plan
- Reset: hold rst=0 with random inputs for 3 cycles, then release. All outputs are 0 throughout reset and on the first edge after release.
- Port 0 only: write 0xABCDEF12 to 0x0, then read 0x0 the next cycle. mem_we=1 on cycle 1. p0_rvalid=1 with p0_rdata=0xABCDEF12 on cycle 3. p0_stall=0 throughout.
- Conflict, with DMEM_ARB_STARVE_EN and MAX_WAIT=4:
  - Port 0 reads every cycle; port 1 requests a write of 0x12345678 to 0x40.
  - p1_gnt=0 for 4 cycles, then p1_gnt=1 and p0_stall=1 on the 5th.
  - mem_addr=0x40 in that cycle; wait_cnt returns to 0 afterwards.
- Conflict without DMEM_ARB_STARVE_EN: same stimulus for 20 cycles. p1_gnt stays 0 and p0_stall stays 0. When p0_req drops, p1_gnt=1 the same cycle.
- Alternating reads: mem_rdata returns 0x11 then 0x22 for a p0 read at 0x8 followed by a p1 read at 0xC.
  - p0_rvalid/p0_rdata=0x11 one cycle after the first grant.
  - p1_rvalid/p1_rdata=0x22 the following cycle.
  - Responses never cross owners.
- Reset mid-read: drive rst=0 in the cycle after a granted p0 read. p0_rvalid stays 0, and no response appears after rst returns to 1.
